// File: rtl/aud_pkg.sv
// Shared types and constants for the audio playback path.
// The DAC serialiser's state encoding lives here so that every consumer sees one definition.
package aud_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int I2S_LEAD_BCLKS = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LEAD,
        S_SHIFT,
        S_PAD
    } dac_state_t;

endpackage

// File: rtl/aud_dac_player_if.sv
// Sample handshake between the SRAM manager (master) and the DAC player (slave).
interface aud_dac_player_if import aud_pkg::*; #(
    parameter int DATA_W = SAMPLE_W
);

    logic signed [DATA_W-1:0] dat;
    logic                     valid;
    logic                     ready;

    modport master (output dat, output valid, input ready);
    modport slave  (input dat, input valid, output ready);

endinterface

// File: rtl/aud_edge_sync.sv
// Brings an asynchronous codec clock pin into i_clk and emits registered
// one-cycle rise/fall strobes, SYNC_STAGES+1 cycles after the pin edge.
module aud_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | SYNC_STAGES'(i_pin);
            r_prev <= w_level;
            r_rise <= w_level & ~r_prev;
            r_fall <= ~w_level & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/aud_dac_player.sv
// I2S playback serialiser: one-entry sample buffer fed over a valid/ready handshake,
// each sample sent MSB-first in both the left and right slot (mono), codec is clock master.
module aud_dac_player import aud_pkg::*; #(
    parameter int DATA_W      = SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_aud_bclk,
    input  logic                   i_aud_daclrck,
    aud_dac_player_if.slave        sram,
    output logic                   o_aud_dacdat,
    output logic                   o_frame,
    output logic                   o_underrun
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    dac_state_t               r_state;
    logic signed [DATA_W-1:0] r_buf;
    logic                     r_buf_full;
    logic signed [DATA_W-1:0] r_play;
    logic signed [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]         r_bit_cnt;
    logic                     r_dacdat;
    logic                     r_ready;
    logic                     r_frame;
    logic                     r_underrun;

    logic                     w_bclk_fall;
    logic                     w_bclk_rise_unused;
    logic                     w_lr_fall;
    logic                     w_lr_rise;
    logic                     w_in_play;
    logic                     w_accept;
    logic                     w_consume;
    logic                     w_buf_full_nxt;
    logic signed [DATA_W-1:0] w_new_play;

    aud_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pin  (i_aud_bclk),
        .o_rise (w_bclk_rise_unused),
        .o_fall (w_bclk_fall)
    );

    aud_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pin  (i_aud_daclrck),
        .o_rise (w_lr_rise),
        .o_fall (w_lr_fall)
    );

    assign w_in_play  = (r_state == S_WAIT) || (r_state == S_LEAD) ||
                        (r_state == S_SHIFT) || (r_state == S_PAD);
    assign w_accept   = sram.valid && r_ready;
    // A left-slot start drains the buffer; an accept in that same cycle refills it for the next frame.
    assign w_consume  = w_lr_fall && w_in_play && r_buf_full;
    assign w_buf_full_nxt = i_en && (w_accept || (r_buf_full && !w_consume));
    assign w_new_play = r_buf_full ? r_buf : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_play     <= '0;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_dacdat   <= 1'b0;
            r_ready    <= 1'b0;
            r_frame    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_frame    <= 1'b0;
            r_underrun <= 1'b0;
            r_buf_full <= w_buf_full_nxt;
            r_ready    <= i_en && !w_buf_full_nxt;
            if (w_accept && i_en) begin
                r_buf <= sram.dat;
            end

            if (!i_en) begin
                r_state   <= S_IDLE;
                r_dacdat  <= 1'b0;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_dacdat <= 1'b0;
                        r_state  <= S_WAIT;
                    end
                    S_WAIT, S_LEAD, S_SHIFT, S_PAD: begin
                        // LRCK edges win over a coincident BCLK fall: that fall is lead edge 0.
                        if (w_lr_fall) begin
                            r_play     <= w_new_play;
                            r_shreg    <= w_new_play;
                            r_underrun <= !r_buf_full;
                            r_frame    <= 1'b1;
                            r_dacdat   <= 1'b0;
                            r_bit_cnt  <= '0;
                            r_state    <= S_LEAD;
                        end else if (r_state == S_WAIT) begin
                            r_dacdat <= 1'b0;
                        end else if (w_lr_rise) begin
                            r_shreg   <= r_play;
                            r_dacdat  <= 1'b0;
                            r_bit_cnt <= '0;
                            r_state   <= S_LEAD;
                        end else if (w_bclk_fall) begin
                            case (r_state)
                                S_LEAD: begin
                                    if (r_bit_cnt == CNT_W'(I2S_LEAD_BCLKS - 1)) begin
                                        r_dacdat  <= r_shreg[DATA_W-1];
                                        r_shreg   <= r_shreg << 1;
                                        r_bit_cnt <= '0;
                                        r_state   <= S_SHIFT;
                                    end else begin
                                        r_dacdat  <= 1'b0;
                                        r_bit_cnt <= r_bit_cnt + 1'b1;
                                    end
                                end
                                S_SHIFT: begin
                                    if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                                        r_dacdat <= 1'b0;
                                        r_state  <= S_PAD;
                                    end else begin
                                        r_dacdat  <= r_shreg[DATA_W-1];
                                        r_shreg   <= r_shreg << 1;
                                        r_bit_cnt <= r_bit_cnt + 1'b1;
                                    end
                                end
                                default: begin
                                    r_dacdat <= 1'b0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        r_dacdat <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sram.ready   = r_ready;
    assign o_aud_dacdat = r_dacdat;
    assign o_frame      = r_frame;
    assign o_underrun   = r_underrun;

endmodule
